// File: rtl/drum_mul_pipe_if.sv
// Operand/result bus of drum_mul_pipe: an operand handshake in and a product handshake out.
// The DUT attaches through the slave modport and the producer/consumer through the master modport.

interface drum_mul_pipe_if #(
  parameter int N = 16
);
  // Both handshakes follow strict valid/ready rules. A transfer happens on a rising
  // edge where valid and ready are both high. A source that raises valid keeps it high,
  // with its data stable, until the transfer. ready_o never looks at valid_i.
  logic [N-1:0]   a_i;
  logic [N-1:0]   b_i;
  logic           valid_i;
  logic           ready_o;
  logic [2*N-1:0] p_o;
  logic           valid_o;
  logic           ready_i;

  modport master (
    output a_i, b_i, valid_i, ready_i,
    input  ready_o, p_o, valid_o
  );

  modport slave (
    input  a_i, b_i, valid_i, ready_i,
    output ready_o, p_o, valid_o
  );
endinterface

// File: rtl/drum_mul_pipe.sv
// DRUM approximate unsigned multiplier, three elastic stages: leading-one window, KxK multiply, shift.
// Define DRUM_UNBIAS_EN to force the LSB of every truncated window to 1; leave it undefined for plain truncation.

module drum_mul_pipe #(
  parameter int N = 16,
  parameter int K = 6
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  drum_mul_pipe_if.slave bus
);

  localparam int SW  = $clog2(N + 1);
  localparam int SSW = SW + 1;

  typedef struct packed {
    logic [K-1:0]  win;
    logic [SW-1:0] sh;
  } lod_t;

  // Operands below 2^K pass through exactly. Larger operands keep the K bits that start at the leading one.
  function automatic lod_t lod(input logic [N-1:0] x);
    lod_t r;
    int   m;
    r.win = '0;
    r.sh  = '0;
    m     = 0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) m = i;
    end
    if (m < K) begin
      r.win = x[K-1:0];
    end else begin
      r.sh  = SW'(m - K + 1);
      r.win = K'(x >> (m - K + 1));
`ifdef DRUM_UNBIAS_EN
      r.win[0] = 1'b1;
`else
      r.win[0] = r.win[0];
`endif
    end
    return r;
  endfunction

  logic           s1_valid, s2_valid, s3_valid;
  logic           s1_en, s2_en, s3_en;
  logic           accept;
  lod_t           lod_a, lod_b;

  logic [K-1:0]   s1_wa, s1_wb;
  logic [SSW-1:0] s1_sh;
  logic [2*K-1:0] s2_prod;
  logic [SSW-1:0] s2_sh;
  logic [2*N-1:0] p_ext, p_next, p_q;

  // A stage may load when it is empty or when the stage after it loads in the same cycle.
  assign s3_en       = !s3_valid || bus.ready_i;
  assign s2_en       = !s2_valid || s3_en;
  assign s1_en       = !s1_valid || s2_en;
  assign bus.ready_o = s1_en;
  assign accept      = bus.valid_i && s1_en;

  always_comb begin
    lod_a = lod(bus.a_i);
    lod_b = lod(bus.b_i);
  end

  always_comb begin
    p_ext            = '0;
    p_ext[2*K-1:0]   = s2_prod;
    p_next           = p_ext << s2_sh;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      p_q      <= '0;
    end else begin
      if (s1_en) s1_valid <= bus.valid_i;
      if (s2_en) s2_valid <= s1_valid;
      if (s3_en) begin
        s3_valid <= s2_valid;
        if (s2_valid) p_q <= p_next;
      end
    end
  end

  // Stage data carries no reset; a clear valid bit is what marks it as meaningless.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_wa <= lod_a.win;
      s1_wb <= lod_b.win;
      s1_sh <= SSW'(lod_a.sh) + SSW'(lod_b.sh);
    end
    if (s2_en && s1_valid) begin
      s2_prod <= (2*K)'(s1_wa) * (2*K)'(s1_wb);
      s2_sh   <= s1_sh;
    end
  end

  assign bus.valid_o = s3_valid;
  assign bus.p_o     = p_q;

endmodule

// File: tb/tb_drum_mul_pipe.sv
// Self-checking bench for drum_mul_pipe (N=16, K=6): directed corner cases, stall, reset, random stream.
// The expected products come from an arithmetic DRUM model and are held in a scoreboard queue.

module tb_drum_mul_pipe;
  localparam int N = 16;
  localparam int K = 6;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   rdy_mode;
  logic [2*N-1:0] exp_q[$];

  drum_mul_pipe_if #(.N(N)) bus ();

  drum_mul_pipe #(.N(N), .K(K)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rdy_mode: 0 = consumer always ready, 1 = consumer stalled, 2 = random
  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.ready_i = 1'b1;
        1:       bus.ready_i = 1'b0;
        default: bus.ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: window from the leading-one position, product shifted back up.
  function automatic void drum_win(input int unsigned x, output longint unsigned w, output int s);
    if (x < (1 << K)) begin
      w = x;
      s = 0;
    end else begin
      s = $clog2(x + 1) - K;
      w = x >> s;
`ifdef DRUM_UNBIAS_EN
      w = w | 1;
`endif
    end
  endfunction

  function automatic logic [2*N-1:0] model(input int unsigned a, input int unsigned b);
    longint unsigned wa, wb;
    int sa, sb;
    drum_win(a, wa, sa);
    drum_win(b, wb, sb);
    return (2*N)'((wa * wb) << (sa + sb));
  endfunction

  // driver tasks
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] exp);
    int n;
    @(negedge clk);
    bus.a_i     = a;
    bus.b_i     = b;
    bus.valid_i = 1'b1;
    n = 0;
    while (!bus.ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) begin
      chk("send_ready_timeout", bus.ready_o, 1);
      bus.valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(exp);
    #1 bus.valid_i = 1'b0;
  endtask

  task automatic send_m(input logic [N-1:0] a, input logic [N-1:0] b);
    send(a, b, model(a, b));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [N-1:0] rnd_op();
    int w;
    w = $urandom_range(0, N);
    return N'($urandom & ((32'h1 << w) - 1));
  endfunction

  // scoreboard: every delivery pops the oldest expected product
  always @(negedge clk) begin
    if (rst_n && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) chk("extra_output", bus.valid_o, 0);
      else chk("product", bus.p_o, exp_q.pop_front());
    end
  end

  initial begin
    logic [2*N-1:0] held;
    int n;
    total       = 0;
    bad         = 0;
    rdy_mode    = 0;
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_p_o", bus.p_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.ready_o, 1);

    // 0x00FF * 3 with the latency checked edge by edge
    send(16'h00FF, 16'h0003, 32'd756);
    @(negedge clk);
    chk("lat_c1", bus.valid_o, 0);
    @(negedge clk);
    chk("lat_c2", bus.valid_o, 0);
    @(negedge clk);
    chk("lat_c3_valid", bus.valid_o, 1);
    chk("lat_c3_p", bus.p_o, 32'd756);
    drain("drain_lat");

    // corner operands
`ifdef DRUM_UNBIAS_EN
    send(16'h0100, 16'h0001, 32'd264);
`else
    send(16'h0100, 16'h0001, 32'd256);
`endif
    send(16'hFFFF, 16'hFFFF, 32'hF810_0000);
    send(16'h0000, 16'hFFFF, 32'd0);
    send(16'h003F, 16'h003F, 32'd3969);
    drain("drain_corner");

    // five back-to-back pairs against a stalled consumer
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 5; i++) send_m(rnd_op(), rnd_op());
      end
      begin
        n = 0;
        while (!bus.valid_o && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("stall_valid", bus.valid_o, 1);
        held = bus.p_o;
        for (int c = 0; c < 4; c++) begin
          chk("stall_ready_low", bus.ready_o, 0);
          chk("stall_p_held", bus.p_o, held);
          @(negedge clk);
        end
        rdy_mode = 0;
      end
    join
    drain("drain_stall");

    // reset with two operations in flight
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    send_m(16'h1234, 16'h00AB);
    send_m(16'h8001, 16'h7FFF);
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", bus.valid_o, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_valid", bus.valid_o, 0);
    chk("async_rst_p", bus.p_o, 0);
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus.ready_o, 1);
    for (int c = 0; c < 6; c++) begin
      chk("no_stale", bus.valid_o, 0);
      @(negedge clk);
    end
    send_m(16'h0FF0, 16'h0101);
    drain("drain_rst");

    // random stream with random consumer back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send_m(rnd_op(), rnd_op());
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rdy_mode = 0;
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=0", 1);
    $fatal(1, "bench timeout");
  end

endmodule
